// File: rtl/line_decoder_hold_if.sv
// Bus between an upstream code source and line_decoder_hold.
//   x, y      : encoded code {x,y}, meaningful only while V is high
//   V         : code valid strobe
//   in_ready  : decoder can take a code this cycle (FIFO not full)
//   D         : one-hot decoded line (or all zero)
//   busy      : decoder has a pulse in flight or codes buffered
//   count     : FIFO occupancy
//   overflow  : sticky flag, a code was offered while full and lost
// master = code source / observer, slave = the decoder.
// DEPTH must match the DEPTH of the decoder instance using this bus.
interface line_decoder_hold_if #(
    parameter int DEPTH = 4
);
    logic                     x;
    logic                     y;
    logic                     V;
    logic                     in_ready;
    logic [3:0]               D;
    logic                     busy;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport master (
        output x, y, V,
        input  in_ready, D, busy, count, overflow
    );

    modport slave (
        input  x, y, V,
        output in_ready, D, busy, count, overflow
    );
endinterface

// File: rtl/line_decoder_hold.sv
// line_decoder_hold
//   Sequential 2-to-4 line decoder. Codes {x,y} qualified by V are queued
//   in a small FIFO and replayed one at a time as a one-hot pulse on D,
//   held for HOLD cycles, separated by GAP idle cycles.
// Ports
//   clock : rising-edge clock
//   reset : asynchronous, active-high; clears FSM, FIFO and overflow at once
//   bus   : line_decoder_hold_if.slave (x, y, V in; in_ready, D, busy,
//           count, overflow out)
// Parameters
//   HOLD  (>=1)  cycles each decoded line stays high
//   GAP   (>=0)  zero cycles between consecutive pulses
//   DEPTH (power of 2, >=2) FIFO entries
module line_decoder_hold #(
    parameter int HOLD  = 4,
    parameter int GAP   = 1,
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    line_decoder_hold_if.slave bus
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXT = (HOLD > GAP) ? HOLD : GAP;
    // Timer only ever holds values 0..MAXT-1.
    localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'((GAP > 0) ? (GAP - 1) : 0);
    localparam bit            NO_GAP    = (GAP == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;

    logic          in_ready;
    logic          push;
    logic          drop;
    logic          pop;
    logic          empty;
    logic [1:0]    head_code;
    logic [3:0]    head_onehot;

    // ------------------------------------------------------------------
    // Output sequencer
    // ------------------------------------------------------------------
    state_t        state_reg;
    logic [TW-1:0] cnt_reg;
    logic [3:0]    d_reg;

    // in_ready looks only at the current occupancy, so a pop in the same
    // cycle never makes room for a push that arrives while full.
    assign in_ready = (count_reg < CW'(DEPTH));
    assign push     = bus.V && in_ready;
    assign drop     = bus.V && !in_ready;
    assign empty    = (count_reg == '0);

    // The head is read asynchronously: a code written at edge k must be
    // decodable at edge k+1, which a registered read port cannot deliver.
    assign head_code = mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_decode
            assign head_onehot[gi] = (head_code == 2'(gi));
        end
    endgenerate

    // Pop whenever the sequencer is about to launch a new pulse.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            case (state_reg)
                ST_IDLE:  pop = 1'b1;
                ST_DRIVE: pop = (cnt_reg == '0) && NO_GAP;
                ST_GAP:   pop = (cnt_reg == '0);
                default:  pop = 1'b0;
            endcase
        end
    end

    // Storage has no reset: stale entries are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= {bus.x, bus.y};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Sequencer: D is registered here so it can only ever take the value
    // of one decoded head entry or zero, never a blend.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            d_reg     <= 4'b0000;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        d_reg     <= head_onehot;
                        cnt_reg   <= HOLD_LOAD;
                        state_reg <= ST_DRIVE;
                    end else begin
                        d_reg <= 4'b0000;
                    end
                end

                ST_DRIVE: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - TW'(1);
                    end else if (!NO_GAP) begin
                        d_reg     <= 4'b0000;
                        cnt_reg   <= GAP_LOAD;
                        state_reg <= ST_GAP;
                    end else if (pop) begin
                        // Back-to-back pulse: one-hot to one-hot directly.
                        d_reg   <= head_onehot;
                        cnt_reg <= HOLD_LOAD;
                    end else begin
                        d_reg     <= 4'b0000;
                        state_reg <= ST_IDLE;
                    end
                end

                ST_GAP: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - TW'(1);
                    end else if (pop) begin
                        d_reg     <= head_onehot;
                        cnt_reg   <= HOLD_LOAD;
                        state_reg <= ST_DRIVE;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    d_reg     <= 4'b0000;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.D        = d_reg;
    assign bus.busy     = (state_reg != ST_IDLE) || !empty;
    assign bus.count    = count_reg;
    assign bus.overflow = overflow_reg;

endmodule
